float_to_fixed_pipe: RTL and testbench

//  Pipelined float -> signed fixed-point converter; inverse of the int->float normaliser.

---
 rtl/float_to_fixed_if.sv | 24 ++
 rtl/float_to_fixed_pipe.sv | 135 +++++++++++++
 tb/tb_float_to_fixed_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_to_fixed_if.sv
// Streaming bus for the float -> fixed converter: float words in, saturated fixed words out.
interface float_to_fixed_if #(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int INT_SIZE      = 32
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] in_float;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [INT_SIZE-1:0]                  out_fixed;
  logic                                 out_ovf;

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_fixed, out_ovf
  );

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_fixed, out_ovf
  );
endinterface

// File: rtl/float_to_fixed_pipe.sv
// Three-stage float -> signed fixed-point converter with truncation toward zero and saturation.
module float_to_fixed_pipe #(
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int INT_SIZE      = 32,
  parameter int FRAC_BITS     = 0
) (
  input logic              clk,
  input logic              reset,
  float_to_fixed_if.slave  bus
);
  localparam int MW     = MANTISSA_SIZE + 1;
  localparam int MAGW   = INT_SIZE + 1;
  localparam int SHW    = EXPONENT_SIZE + 2;
  localparam int WW     = MAGW + MW;
  localparam int BIAS   = 2 ** (EXPONENT_SIZE - 1) - 1;
  localparam int SH_OFS = BIAS + MANTISSA_SIZE - FRAC_BITS;
  localparam int LIM    = INT_SIZE - MANTISSA_SIZE - 1;

  localparam logic [SHW-1:0]        SH_OFS_V = SHW'(SH_OFS);
  localparam logic signed [SHW-1:0] LIM_S    = SHW'(LIM);
  localparam logic [SHW-1:0]        MW_V     = SHW'(MW);
  localparam logic [INT_SIZE-1:0]   MAXP     = {1'b0, {(INT_SIZE-1){1'b1}}};
  localparam logic [INT_SIZE-1:0]   MINN     = {1'b1, {(INT_SIZE-1){1'b0}}};

  function automatic logic [INT_SIZE:0] saturate(
    input logic            sign,
    input logic            spec,
    input logic            nan,
    input logic            big,
    input logic [MAGW-1:0] mag
  );
    if (spec) begin
      if (nan || !sign) return {1'b1, MAXP};
      return {1'b1, MINN};
    end
    if (!sign) begin
      if (big || (mag > {1'b0, MAXP})) return {1'b1, MAXP};
      return {1'b0, mag[INT_SIZE-1:0]};
    end
    if (big || (mag > {1'b0, MINN})) return {1'b1, MINN};
    return {1'b0, -mag[INT_SIZE-1:0]};
  endfunction

  logic adv;
  logic vld_p1, vld_p2, vld_p3;

  logic                     sign_p1, zero_p1, spec_p1, nan_p1;
  logic [MW-1:0]            man_p1;
  logic signed [SHW-1:0]    sh_p1;
  logic                     sign_p2, spec_p2, nan_p2, big_p2;
  logic [MAGW-1:0]          mag_p2;
  logic [INT_SIZE-1:0]      fixed_p3;
  logic                     ovf_p3;

  logic [EXPONENT_SIZE-1:0] exp_in;
  logic [WW-1:0]            wide;
  logic [SHW-1:0]           nsh;
  logic [MAGW-1:0]          mag_c;
  logic                     big_c;
  logic [INT_SIZE:0]        sat_c;

  // Whole pipeline moves together; only a full, unaccepted output stage stalls it.
  assign adv           = !vld_p3 || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p3;
  assign bus.out_fixed = fixed_p3;
  assign bus.out_ovf   = ovf_p3;

  assign exp_in = bus.in_float[EXPONENT_SIZE+MANTISSA_SIZE-1:MANTISSA_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // p1: unpack fields, classify, compute binary-point shift
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1 <= bus.in_float[EXPONENT_SIZE+MANTISSA_SIZE];
      zero_p1 <= (exp_in == '0);
      spec_p1 <= &exp_in;
      nan_p1  <= |bus.in_float[MANTISSA_SIZE-1:0];
      man_p1  <= {1'b1, bus.in_float[MANTISSA_SIZE-1:0]};
      sh_p1   <= {2'b00, exp_in} - SH_OFS_V;
    end
  end

  // p2: de-normalise the mantissa; zero/special carry a clean magnitude
  always_comb begin
    wide  = '0;
    mag_c = '0;
    big_c = 1'b0;
    nsh   = -sh_p1;
    if (!zero_p1 && !spec_p1) begin
      if (!sh_p1[SHW-1]) begin
        wide  = WW'(man_p1) << $unsigned(sh_p1);
        big_c = (sh_p1 > LIM_S) || (|wide[WW-1:MAGW]);
        mag_c = wide[MAGW-1:0];
      end else if (nsh < MW_V) begin
        mag_c = MAGW'(man_p1 >> nsh);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p2 <= sign_p1;
      spec_p2 <= spec_p1 && !zero_p1;
      nan_p2  <= nan_p1;
      big_p2  <= big_c;
      mag_p2  <= mag_c;
    end
  end

  // p3: apply sign and saturate to the signed output range
  assign sat_c = saturate(sign_p2, spec_p2, nan_p2, big_p2, mag_p2);

  always_ff @(posedge clk) begin
    if (reset) begin
      fixed_p3 <= '0;
      ovf_p3   <= 1'b0;
    end else if (adv) begin
      fixed_p3 <= sat_c[INT_SIZE-1:0];
      ovf_p3   <= sat_c[INT_SIZE];
    end
  end
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Randomized and directed bench for float_to_fixed_pipe against a value-level reference model.
module tb_float_to_fixed_pipe;
  typedef struct packed {
    logic [31:0] fx;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;
  exp_t sbq[$];
  exp_t cur_exp;
  logic stall_prev = 1'b0;
  logic [31:0] hold_fx;
  logic        hold_ovf;

  float_to_fixed_if #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32)) bus ();
  float_to_fixed_if #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32)) bus8 ();

  float_to_fixed_pipe #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32), .FRAC_BITS(0)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  float_to_fixed_pipe #(.EXPONENT_SIZE(8), .MANTISSA_SIZE(23), .INT_SIZE(32), .FRAC_BITS(8)) dut8 (
    .clk(clk), .reset(rst), .bus(bus8)
  );

  always #5 clk = ~clk;

  // Value-level reference: scale 1.m by 2^(e-bias+frac), truncate toward zero, clamp.
  function automatic exp_t model(input logic [31:0] f, input int frac);
    exp_t r;
    logic [127:0] mag;
    int e, k;
    e = int'(f[30:23]);
    if (e == 0) return '{32'h0, 1'b0};
    if (e == 255) begin
      if (f[22:0] != 0 || !f[31]) return '{32'h7FFFFFFF, 1'b1};
      return '{32'h80000000, 1'b1};
    end
    k = e - 150 + frac;
    if (k > 90)       mag = 128'h1 << 100;
    else if (k >= 0)  mag = {104'b0, 1'b1, f[22:0]} << k;
    else if (-k >= 24) mag = '0;
    else              mag = {104'b0, 1'b1, f[22:0]} >> (-k);
    if (!f[31]) begin
      if (mag > 128'h7FFFFFFF) r = '{32'h7FFFFFFF, 1'b1};
      else                     r = '{mag[31:0], 1'b0};
    end else begin
      if (mag > 128'h80000000) r = '{32'h80000000, 1'b1};
      else                     r = '{32'(0 - mag[31:0]), 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int r;
    r = int'($urandom % 16);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else             e = 8'($urandom_range(110, 165));
    return {1'($urandom % 2), e, 23'($urandom)};
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom % 2);
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_fixed", 64'(bus.out_fixed), 64'(hold_fx));
        chk("hold_ovf", 64'(bus.out_ovf), 64'(hold_ovf));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out got=%h want=none", bus.out_fixed);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_fixed", 64'(bus.out_fixed), 64'(e.fx));
          chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready) sbq.push_back(cur_exp);
      stall_prev = bus.out_valid && !bus.out_ready;
      hold_fx    = bus.out_fixed;
      hold_ovf   = bus.out_ovf;
    end
  end

  task automatic send(input logic [31:0] f, input exp_t e);
    int n;
    bus.in_valid = 1'b1;
    bus.in_float = f;
    cur_exp      = e;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=stalled want=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  logic [31:0] dv_in [15] = '{32'h3F800000, 32'hC0200000, 32'h4F000000, 32'hCF000000,
                              32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h80000000,
                              32'h7F800000, 32'hFFC00000, 32'hCF000001, 32'h4EFFFFFF,
                              32'h3F000000, 32'hBF7FFFFF, 32'h5F000000};
  logic [31:0] dv_fx [15] = '{32'h00000001, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000,
                              32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80,
                              32'h00000000, 32'h00000000, 32'h7FFFFFFF};
  logic        dv_ov [15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    exp_t m;
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_float = '0;
    bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.in_float = '0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_fixed", 64'(bus.out_fixed), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 15; i++) begin
      m = model(dv_in[i], 0);
      chk($sformatf("model_pin_%0d", i), {31'b0, m.ovf, m.fx}, {31'b0, dv_ov[i], dv_fx[i]});
    end
    m = model(32'h3FC00000, 8);
    chk("model_pin_frac8", {31'b0, m.ovf, m.fx}, {31'b0, 1'b0, 32'h00000180});

    @(posedge clk);
    #1;
    send(dv_in[0], '{dv_fx[0], dv_ov[0]});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    chk("latency_1p0", 64'(n), 64'd3);
    drain();

    for (int i = 1; i < 15; i++) send(dv_in[i], '{dv_fx[i], dv_ov[i]});
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = rand_float();
      send(w, model(w, 0));
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      w = rand_float();
      send(w, model(w, 0));
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    send(32'h40400000, model(32'h40400000, 0));
    send(32'hC1200000, model(32'hC1200000, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    send(32'h41200000, '{32'h0000000A, 1'b0});
    drain();

    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1;
    bus8.in_float = 32'h3FC00000;
    @(posedge clk);
    #1;
    bus8.in_float = 32'hC0200000;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.out_valid && n < 10);
    chk("frac8_valid_a", 64'(bus8.out_valid), 64'd1);
    chk("frac8_1p5", {31'b0, bus8.out_ovf, bus8.out_fixed}, {31'b0, 1'b0, 32'h00000180});
    @(negedge clk);
    m = model(32'hC0200000, 8);
    chk("frac8_valid_b", 64'(bus8.out_valid), 64'd1);
    chk("frac8_m2p5", {31'b0, bus8.out_ovf, bus8.out_fixed}, {31'b0, m.ovf, m.fx});
    chk("frac8_m2p5_lit", 64'(bus8.out_fixed), 64'hFFFFFD80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
